// File: rtl/alu_pkg.sv
// Opcode map, FSM state type and mul/div classification shared by the EX-stage ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Codes 16..23 form the M-extension block.
    function automatic logic is_muldiv(input logic [4:0] code);
        return code[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX-to-EX/MEM ALU bundle; master drives operands, slave is the ALU stage.
interface ex_alu_stage_if #(parameter int XLEN = 32);

    logic            in_valid_i;
    logic [4:0]      alu_ctrl_i;
    logic            alu_op2_sel_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [XLEN-1:0] sz_alu_i;
    logic            flush_i;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            out_valid_o;
    logic            stall_o;

    modport master (
        output in_valid_i, alu_ctrl_i, alu_op2_sel_i, op1_i, op2_i, sz_alu_i, flush_i,
        input  result_o, zero_o, out_valid_o, stall_o
    );

    modport slave (
        input  in_valid_i, alu_ctrl_i, alu_op2_sel_i, op1_i, op2_i, sz_alu_i, flush_i,
        output result_o, zero_o, out_valid_o, stall_o
    );

endinterface

// File: rtl/ex_muldiv_iter.sv
// Radix-2 iterative multiply/divide engine on operand magnitudes, sign-corrected on output.
// Used by ex_alu_stage only when EX_MULDIV_EN is defined.
module ex_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb_mag;
    logic [CW-1:0]     cnt;
    logic              is_div, is_hi, is_rem, neg, div0;

    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_part;
    logic [XLEN-1:0]   div_diff, div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    // op[2] selects divide; for divide op[0]=unsigned, for multiply op[1:0] picks the signedness pair.
    always_comb begin
        if (op[2]) begin
            sgn_a = !op[0] && a[XLEN-1];
            sgn_b = !op[0] && b[XLEN-1];
        end else begin
            sgn_a = (op[1:0] == 2'b01 || op[1:0] == 2'b10) && a[XLEN-1];
            sgn_b = (op[1:0] == 2'b01) && b[XLEN-1];
        end
        mag_a = sgn_a ? -a : a;
        mag_b = sgn_b ? -b : b;
    end

    // Multiplier occupies acc low half and is consumed LSB first; the dividend shifts out MSB first.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_mag} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_part = acc[2*XLEN-1:XLEN-1];
        div_ge   = div_part >= {1'b0, opb_mag};
        div_diff = div_part[XLEN-1:0] - opb_mag;
        div_rem  = div_ge ? div_diff : div_part[XLEN-1:0];
        div_next = {div_rem, acc[XLEN-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            opb_mag <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            is_hi   <= 1'b0;
            is_rem  <= 1'b0;
            neg     <= 1'b0;
            div0    <= 1'b0;
        end else if (kill) begin
            cnt <= '0;
        end else if (start) begin
            acc     <= {{XLEN{1'b0}}, mag_a};
            opb_mag <= mag_b;
            cnt     <= '0;
            is_div  <= op[2];
            is_hi   <= op[1:0] != 2'b00;
            is_rem  <= op[1];
            neg     <= (op[2] && op[1]) ? sgn_a : (sgn_a ^ sgn_b);
            div0    <= b == '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? div_next : mul_next;
        end
    end

    assign last = cnt == CW'(XLEN - 1);
    assign prod = neg ? -acc : acc;

    always_comb begin
        result = '0;
        if (!is_div) begin
            result = is_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end else if (is_rem) begin
            result = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else if (div0) begin
            result = '1;
        end else begin
            result = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        end
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: operand-B mux, single-cycle ALU, control FSM and EX/MEM output registers.
// Define EX_MULDIV_EN to add the iterative M-extension engine and its stall path.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_alu_stage_if.slave bus
);

    logic [XLEN-1:0] opb, alu_res, md_result;
    logic            md_op, md_last, accept_sc, accept_md;
    state_t          state, state_next;

    assign opb = bus.alu_op2_sel_i ? bus.sz_alu_i : bus.op2_i;

    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl_i)
            ALU_ADD:   alu_res = bus.op1_i + opb;
            ALU_SUB:   alu_res = bus.op1_i - opb;
            ALU_SLL:   alu_res = bus.op1_i << opb[4:0];
            ALU_SRL:   alu_res = bus.op1_i >> opb[4:0];
            ALU_SRA:   alu_res = $unsigned($signed(bus.op1_i) >>> opb[4:0]);
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.op1_i) < $signed(opb)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, bus.op1_i < opb};
            ALU_XOR:   alu_res = bus.op1_i ^ opb;
            ALU_OR:    alu_res = bus.op1_i | opb;
            ALU_AND:   alu_res = bus.op1_i & opb;
            ALU_PASSB: alu_res = opb;
            default:   alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    assign md_op       = is_muldiv(bus.alu_ctrl_i);
    assign bus.stall_o = ((state == IDLE) && bus.in_valid_i && md_op) || (state == BUSY);

    ex_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept_md),
        .kill   (bus.flush_i),
        .step   (state == BUSY),
        .op     (bus.alu_ctrl_i[2:0]),
        .a      (bus.op1_i),
        .b      (opb),
        .last   (md_last),
        .result (md_result)
    );
`else
    assign md_op       = 1'b0;
    assign md_last     = 1'b0;
    assign md_result   = '0;
    assign bus.stall_o = 1'b0;
`endif

    assign accept_sc = (state == IDLE) && bus.in_valid_i && !bus.flush_i && !md_op;
    assign accept_md = (state == IDLE) && bus.in_valid_i && !bus.flush_i && md_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept_md) state_next = BUSY;
                BUSY:    if (md_last) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Inputs seen while in DONE belong to the completing instruction and are not re-accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result_o    <= '0;
            bus.zero_o      <= 1'b0;
            bus.out_valid_o <= 1'b0;
        end else if (bus.flush_i) begin
            bus.out_valid_o <= 1'b0;
        end else if (accept_sc) begin
            bus.result_o    <= alu_res;
            bus.zero_o      <= alu_res == '0;
            bus.out_valid_o <= 1'b1;
        end else if (state == DONE) begin
            bus.result_o    <= md_result;
            bus.zero_o      <= md_result == '0;
            bus.out_valid_o <= 1'b1;
        end else begin
            bus.out_valid_o <= 1'b0;
        end
    end

endmodule
